// File: rtl/mul_k_pkg.sv
// mul_k_pkg: shared constants and helpers for the K-scaling multiplier.
//   DEF_*        default widths, shift and latency of mul_k_scale
//   FULL_W       full product width for the default widths
//   round_const  round-half-up addend used ahead of the right shift
package mul_k_pkg;

  localparam int DEF_A_W   = 16;
  localparam int DEF_K_W   = 20;
  localparam int DEF_P_W   = 30;
  localparam int DEF_SHIFT = 6;
  localparam int DEF_LAT   = 3;

  localparam int FULL_W = DEF_A_W + DEF_K_W;

  // Half an output LSB in product units; zero when no bits are shifted out.
  function automatic logic [63:0] round_const(input int shift);
    if (shift > 0) return 64'd1 << (shift - 1);
    else           return 64'd0;
  endfunction

endpackage

// File: rtl/mul_k_round_sat.sv
// mul_k_round_sat: combinational round-half-up, right shift and width limit
// of an IN_W-bit unsigned product down to P_W bits.
//   full_i  unsigned product
//   r_o     rounded/shifted/limited result
//   sat_o   result was clamped to all-ones
// Build option MUL_K_SCALE_SAT_EN: when defined, results that do not fit in
// P_W bits clamp to 2^P_W-1 with sat_o=1; when undefined they wrap to the low
// P_W bits and sat_o is tied low (no overflow compare is built).
module mul_k_round_sat
  import mul_k_pkg::*;
#(
  parameter int IN_W  = FULL_W,
  parameter int P_W   = DEF_P_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic [IN_W-1:0] full_i,
  output logic [P_W-1:0]  r_o,
  output logic            sat_o
);

  localparam logic [IN_W:0] RND = (IN_W+1)'(round_const(SHIFT));

  // One extra bit so the rounding add can never wrap.
  logic [IN_W:0] sum;
  logic [IN_W:0] r_full;

  always_comb begin
    sum    = {1'b0, full_i} + RND;
    r_full = sum >> SHIFT;
  end

`ifdef MUL_K_SCALE_SAT_EN
  generate
    if (IN_W + 1 > P_W) begin : g_sat
      logic ovf;
      assign ovf   = |r_full[IN_W:P_W];
      assign r_o   = ovf ? '1 : r_full[P_W-1:0];
      assign sat_o = ovf;
    end else begin : g_fit
      assign r_o   = P_W'(r_full);
      assign sat_o = 1'b0;
    end
  endgenerate
`else
  assign r_o   = P_W'(r_full);
  assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/mul_k_scale.sv
// mul_k_scale: pipelined unsigned sample x coefficient scaler with
// valid/ready handshake and full back-pressure.
//   clk, rst_n          clock, async active-low reset
//   k_load, k_in        one-cycle strobe loading the coefficient register
//   s_valid/s_ready/s_data   input sample stream
//   m_valid/m_ready/m_data/m_sat  output stream; m_sat qualified by m_valid
// Pipeline: stage 0 (sample + coefficient), LAT-2 product stages, final
// registered round/shift/limit; accept-to-output latency is LAT cycles.
// Build option MUL_K_SCALE_SAT_EN selects clamp-on-overflow (see
// mul_k_round_sat); latency is the same in both builds.
module mul_k_scale
  import mul_k_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int K_W   = DEF_K_W,
  parameter int P_W   = DEF_P_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int LAT   = DEF_LAT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           k_load,
  input  logic [K_W-1:0] k_in,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [A_W-1:0] s_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [P_W-1:0] m_data,
  output logic           m_sat
);

  localparam int PROD_W = A_W + K_W;

  logic           en;
  logic [K_W-1:0] coef_q, coef_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic [A_W-1:0] a_q, a_d;
  logic [K_W-1:0] k_q, k_d;
  logic [PROD_W-1:0] prod_c;
  logic [PROD_W-1:0] prod_last;
  logic [P_W-1:0] r_c, data_q, data_d;
  logic           sat_c, sat_q, sat_d;

  // Single global enable: the whole pipe advances unless the output is stuck.
  assign en      = !vld_q[LAT-1] || m_ready;
  assign s_ready = en;
  assign m_valid = vld_q[LAT-1];
  assign m_data  = data_q;
  assign m_sat   = sat_q;

  always_comb begin
    // Coefficient loads independently of the stall; stage 0 samples the
    // pre-load value, so a same-cycle accept uses the old coefficient.
    coef_d = k_load ? k_in : coef_q;
    vld_d  = en ? {vld_q[LAT-2:0], s_valid} : vld_q;
    a_d    = a_q;
    k_d    = k_q;
    if (en && s_valid) begin
      a_d = s_data;
      k_d = coef_q;
    end
    prod_c = PROD_W'(a_q) * PROD_W'(k_q);
    data_d = data_q;
    sat_d  = sat_q;
    if (en && vld_q[LAT-2]) begin
      data_d = r_c;
      sat_d  = sat_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_q <= '0;
      vld_q  <= '0;
      a_q    <= '0;
      k_q    <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      coef_q <= coef_d;
      vld_q  <= vld_d;
      a_q    <= a_d;
      k_q    <= k_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  // Product stages carry no reset so synthesis is free to retime the
  // multiplier across them; their contents are only used when valid.
  generate
    if (LAT > 2) begin : g_mid
      logic [PROD_W-1:0] prod_q [LAT-2];
      logic [PROD_W-1:0] prod_d [LAT-2];

      always_comb begin
        for (int i = 0; i < LAT - 2; i++) prod_d[i] = prod_q[i];
        if (en && vld_q[0]) prod_d[0] = prod_c;
        for (int i = 1; i < LAT - 2; i++) begin
          if (en && vld_q[i]) prod_d[i] = prod_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        for (int i = 0; i < LAT - 2; i++) prod_q[i] <= prod_d[i];
      end

      assign prod_last = prod_q[LAT-3];
    end else begin : g_nomid
      assign prod_last = prod_c;
    end
  endgenerate

  mul_k_round_sat #(
    .IN_W  (PROD_W),
    .P_W   (P_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .full_i (prod_last),
    .r_o    (r_c),
    .sat_o  (sat_c)
  );

endmodule
